// File: rtl/ram_ctrl_pkg.sv
// Shared constants, op encodings and FSM state type for the RAM_4K initiator.
// Build option RAM_INIT_CLEAR_EN adds the post-reset CLR state.
package ram_ctrl_pkg;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 16;

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_FILL  = 2'b10;
    localparam logic [1:0] OP_COPY  = 2'b11;

    localparam logic [ADDR_W-1:0] CLR_LAST = {ADDR_W{1'b1}};

`ifdef RAM_INIT_CLEAR_EN
    typedef enum logic [2:0] {IDLE, RD, WR, FL, CP_RD, CP_WR, DONE, CLR} state_t;
`else
    typedef enum logic [2:0] {IDLE, RD, WR, FL, CP_RD, CP_WR, DONE} state_t;
`endif

endpackage

// File: rtl/ram_ctrl_addr_gen.sv
// Block-move address generator: wrapping src/dst pointers plus remaining-word count.
// Zero latency on outputs (pointers are registers); load wins over step; no backpressure.
// The remaining count saturates at zero so "last" stays asserted.
module ram_ctrl_addr_gen
    import ram_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              step_src,
    input  logic              step_dst,
    input  logic [ADDR_W-1:0] src_base,
    input  logic [ADDR_W-1:0] dst_base,
    input  logic [ADDR_W-1:0] len,
    output logic [ADDR_W-1:0] src_ptr,
    output logic [ADDR_W-1:0] dst_ptr,
    output logic [ADDR_W-1:0] dst_next,
    output logic              last
);

    logic [ADDR_W-1:0] remain;

    assign dst_next = dst_ptr + ADDR_W'(1);
    assign last     = (remain == '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            src_ptr <= '0;
            dst_ptr <= '0;
            remain  <= '0;
        end else if (load) begin
            src_ptr <= src_base;
            dst_ptr <= dst_base;
            remain  <= len;
        end else begin
            if (step_src) src_ptr <= src_ptr + ADDR_W'(1);
            // A word is retired when its destination write is done.
            if (step_dst) begin
                dst_ptr <= dst_next;
                if (!last) remain <= remain - ADDR_W'(1);
            end
        end
    end

endmodule

// File: rtl/ram_4k_initiator.sv
// RAM_4K initiator: READ/WRITE/FILL/COPY sequencing; RAM_INIT_CLEAR_EN adds a post-reset clear.
// Latency: READ/WRITE pulse RSP_VALID on the 1st edge after accept, FILL after LEN+1, COPY after 2*(LEN+1).
// Backpressure: CMD_READY only in IDLE; RSP_VALID is a one-cycle pulse with no backpressure.
module ram_4k_initiator
    import ram_ctrl_pkg::*;
(
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              CMD_VALID,
    output logic              CMD_READY,
    input  logic [1:0]        CMD_OP,
    input  logic [ADDR_W-1:0] CMD_SRC,
    input  logic [ADDR_W-1:0] CMD_DST,
    input  logic [ADDR_W-1:0] CMD_LEN,
    input  logic [DATA_W-1:0] CMD_DATA,
    output logic              RSP_VALID,
    output logic [DATA_W-1:0] RSP_DATA,
    output logic              BUSY,
    output logic              MEM_E,
    output logic              MEM_W,
    output logic              MEM_R,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic [DATA_W-1:0] MEM_D,
    input  logic [DATA_W-1:0] MEM_Q
);

    state_t            state;
    logic              accept;
    logic              ag_last;
    logic [ADDR_W-1:0] src_ptr;
    logic [ADDR_W-1:0] dst_ptr;
    logic [ADDR_W-1:0] dst_next;

    assign accept = CMD_VALID && CMD_READY;

    ram_ctrl_addr_gen u_addr_gen (
        .clk      (CLK),
        .rst_n    (RST_N),
        .load     (accept),
        .step_src (state == CP_RD),
        .step_dst ((state == FL || state == CP_WR) && !ag_last),
        .src_base (CMD_SRC),
        .dst_base (CMD_DST),
        .len      (CMD_LEN),
        .src_ptr  (src_ptr),
        .dst_ptr  (dst_ptr),
        .dst_next (dst_next),
        .last     (ag_last)
    );

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
`ifdef RAM_INIT_CLEAR_EN
            state <= CLR;
`else
            state <= IDLE;
`endif
            CMD_READY <= 1'b0;
            RSP_VALID <= 1'b0;
            RSP_DATA  <= '0;
            BUSY      <= 1'b0;
            MEM_E     <= 1'b0;
            MEM_W     <= 1'b0;
            MEM_R     <= 1'b0;
            MEM_ADDR  <= '0;
            MEM_D     <= '0;
        end else begin
            RSP_VALID <= 1'b0;
            RSP_DATA  <= '0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        CMD_READY <= 1'b0;
                        BUSY      <= 1'b1;
                        MEM_E     <= 1'b1;
                        case (CMD_OP)
                            OP_READ: begin
                                state    <= RD;
                                MEM_R    <= 1'b1;
                                MEM_ADDR <= CMD_SRC;
                            end
                            OP_WRITE: begin
                                state    <= WR;
                                MEM_W    <= 1'b1;
                                MEM_ADDR <= CMD_DST;
                                MEM_D    <= CMD_DATA;
                            end
                            OP_FILL: begin
                                state    <= FL;
                                MEM_W    <= 1'b1;
                                MEM_ADDR <= CMD_DST;
                                MEM_D    <= CMD_DATA;
                            end
                            default: begin
                                state    <= CP_RD;
                                MEM_R    <= 1'b1;
                                MEM_ADDR <= CMD_SRC;
                            end
                        endcase
                    end else begin
                        CMD_READY <= 1'b1;
                    end
                end
                RD: begin
                    state     <= DONE;
                    RSP_VALID <= 1'b1;
                    RSP_DATA  <= MEM_Q;
                    MEM_E     <= 1'b0;
                    MEM_R     <= 1'b0;
                end
                WR: begin
                    state     <= DONE;
                    RSP_VALID <= 1'b1;
                    MEM_E     <= 1'b0;
                    MEM_W     <= 1'b0;
                    MEM_D     <= '0;
                end
                FL: begin
                    if (ag_last) begin
                        state     <= DONE;
                        RSP_VALID <= 1'b1;
                        MEM_E     <= 1'b0;
                        MEM_W     <= 1'b0;
                        MEM_D     <= '0;
                    end else begin
                        MEM_ADDR <= dst_next;
                    end
                end
                CP_RD: begin
                    // MEM_D doubles as the hold register for the word in flight.
                    state    <= CP_WR;
                    MEM_R    <= 1'b0;
                    MEM_W    <= 1'b1;
                    MEM_ADDR <= dst_ptr;
                    MEM_D    <= MEM_Q;
                end
                CP_WR: begin
                    MEM_W <= 1'b0;
                    MEM_D <= '0;
                    if (ag_last) begin
                        state     <= DONE;
                        RSP_VALID <= 1'b1;
                        MEM_E     <= 1'b0;
                    end else begin
                        state    <= CP_RD;
                        MEM_R    <= 1'b1;
                        MEM_ADDR <= src_ptr;
                    end
                end
                DONE: begin
                    state     <= IDLE;
                    BUSY      <= 1'b0;
                    CMD_READY <= 1'b1;
                end
`ifdef RAM_INIT_CLEAR_EN
                CLR: begin
                    if (MEM_W && MEM_ADDR == CLR_LAST) begin
                        state     <= IDLE;
                        BUSY      <= 1'b0;
                        CMD_READY <= 1'b1;
                        MEM_E     <= 1'b0;
                        MEM_W     <= 1'b0;
                    end else begin
                        // MEM_W is low only on the first cycle after reset.
                        BUSY     <= 1'b1;
                        MEM_E    <= 1'b1;
                        MEM_W    <= 1'b1;
                        MEM_D    <= '0;
                        MEM_ADDR <= MEM_W ? MEM_ADDR + ADDR_W'(1) : '0;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_4k_initiator.sv
// Bench for ram_4k_initiator: RAM model, command-level reference memory, directed and random commands.
// Honours RAM_INIT_CLEAR_EN when defined.
module tb_ram_4k_initiator;
    import ram_ctrl_pkg::*;

    logic              CLK = 1'b0;
    logic              RST_N;
    logic              CMD_VALID;
    logic              CMD_READY;
    logic [1:0]        CMD_OP;
    logic [11:0]       CMD_SRC;
    logic [11:0]       CMD_DST;
    logic [11:0]       CMD_LEN;
    logic [15:0]       CMD_DATA;
    logic              RSP_VALID;
    logic [15:0]       RSP_DATA;
    logic              BUSY;
    logic              MEM_E;
    logic              MEM_W;
    logic              MEM_R;
    logic [11:0]       MEM_ADDR;
    logic [15:0]       MEM_D;
    logic [15:0]       MEM_Q;

    logic [15:0] mem     [4096];
    logic [15:0] ref_mem [4096];

    int checks = 0;
    int errors = 0;
    int n_wr = 0, n_rd = 0, n_rsp = 0, n_both = 0, n_ebad = 0, n_dbad = 0;
    bit mon_en = 1'b0;

    always #5 CLK = ~CLK;

    ram_4k_initiator dut (
        .CLK(CLK), .RST_N(RST_N), .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
        .CMD_OP(CMD_OP), .CMD_SRC(CMD_SRC), .CMD_DST(CMD_DST), .CMD_LEN(CMD_LEN),
        .CMD_DATA(CMD_DATA), .RSP_VALID(RSP_VALID), .RSP_DATA(RSP_DATA), .BUSY(BUSY),
        .MEM_E(MEM_E), .MEM_W(MEM_W), .MEM_R(MEM_R), .MEM_ADDR(MEM_ADDR),
        .MEM_D(MEM_D), .MEM_Q(MEM_Q)
    );

    // RAM_4K model: combinational read, write at the closing edge of a write cycle.
    assign MEM_Q = (MEM_E && MEM_R) ? mem[MEM_ADDR] : 16'h0;
    always @(posedge CLK) if (MEM_E === 1'b1 && MEM_W === 1'b1) mem[MEM_ADDR] = MEM_D;

    always @(negedge CLK) begin
        if (mon_en) begin
            if (MEM_W === 1'b1) n_wr++;
            if (MEM_R === 1'b1) n_rd++;
            if (RSP_VALID === 1'b1) n_rsp++;
            if (MEM_R === 1'b1 && MEM_W === 1'b1) n_both++;
            if (MEM_E !== (MEM_R | MEM_W)) n_ebad++;
            if (MEM_W !== 1'b1 && MEM_D !== 16'h0) n_dbad++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (CMD_READY !== 1'b1 && n < 10000) begin
            @(posedge CLK); #1;
            n++;
        end
        chk("cmd_ready_wait", 32'(CMD_READY), 32'h1);
    endtask

    // Reference semantics: whole-command effect on memory, expected cycle counts from the op rules.
    task automatic do_cmd(input logic [1:0] op, input logic [11:0] src, input logic [11:0] dst,
                          input logic [11:0] len, input logic [15:0] data, output logic [15:0] rsp);
        int n, wr0, rd0, rsp0, exp_n, exp_wr, exp_rd;
        logic [15:0] exp_data;
        logic [11:0] a, b;
        exp_data = 16'h0;
        case (op)
            OP_READ: begin
                exp_data = ref_mem[src];
                exp_n = 1; exp_wr = 0; exp_rd = 1;
            end
            OP_WRITE: begin
                ref_mem[dst] = data;
                exp_n = 1; exp_wr = 1; exp_rd = 0;
            end
            OP_FILL: begin
                for (int i = 0; i <= int'(len); i++) begin
                    a = dst + 12'(i);
                    ref_mem[a] = data;
                end
                exp_n = int'(len) + 1; exp_wr = exp_n; exp_rd = 0;
            end
            default: begin
                for (int i = 0; i <= int'(len); i++) begin
                    a = src + 12'(i);
                    b = dst + 12'(i);
                    ref_mem[b] = ref_mem[a];
                end
                exp_n = 2 * (int'(len) + 1); exp_wr = int'(len) + 1; exp_rd = exp_wr;
            end
        endcase
        wait_ready();
        CMD_OP = op; CMD_SRC = src; CMD_DST = dst; CMD_LEN = len; CMD_DATA = data;
        CMD_VALID = 1'b1;
        @(posedge CLK); #1;
        wr0 = n_wr; rd0 = n_rd; rsp0 = n_rsp;
        chk("busy_after_accept", 32'(BUSY), 32'h1);
        chk("ready_low_while_busy", 32'(CMD_READY), 32'h0);
        // Keep offering a different command while busy; it must be neither accepted nor leak into fields.
        CMD_OP = 2'($urandom); CMD_SRC = 12'($urandom); CMD_DST = 12'($urandom);
        CMD_LEN = 12'($urandom); CMD_DATA = 16'($urandom);
        n = 0;
        do begin
            @(posedge CLK); #1;
            n++;
        end while (RSP_VALID !== 1'b1 && n < 9000);
        CMD_VALID = 1'b0;
        rsp = RSP_DATA;
        chk("rsp_latency_edges", 32'(n), 32'(exp_n));
        chk("rsp_data", 32'(RSP_DATA), 32'(exp_data));
        chk("write_cycles", 32'(n_wr - wr0), 32'(exp_wr));
        chk("read_cycles", 32'(n_rd - rd0), 32'(exp_rd));
        @(posedge CLK); #1;
        chk("rsp_single_cycle", 32'(RSP_VALID), 32'h0);
        chk("rsp_count", 32'(n_rsp - rsp0), 32'h1);
        chk("ready_after_done", 32'(CMD_READY), 32'h1);
        chk("busy_after_done", 32'(BUSY), 32'h0);
    endtask

    logic [15:0] r;
    logic [15:0] v;
    logic [11:0] ad;
    int n, wr0, rsp0, bad;

    initial begin
        RST_N = 1'b0; CMD_VALID = 1'b0; CMD_OP = 2'b00;
        CMD_SRC = '0; CMD_DST = '0; CMD_LEN = '0; CMD_DATA = '0;
        for (int i = 0; i < 4096; i++) begin
`ifdef RAM_INIT_CLEAR_EN
            mem[i] = 16'hFFFF;
            ref_mem[i] = 16'h0;
`else
            v = 16'($urandom);
            mem[i] = v;
            ref_mem[i] = v;
`endif
        end

        repeat (3) @(posedge CLK);
        #1;
        chk("rst_cmd_ready", 32'(CMD_READY), 32'h0);
        chk("rst_busy", 32'(BUSY), 32'h0);
        chk("rst_rsp_valid", 32'(RSP_VALID), 32'h0);
        chk("rst_rsp_data", 32'(RSP_DATA), 32'h0);
        chk("rst_mem_strobes", 32'({MEM_E, MEM_W, MEM_R}), 32'h0);
        chk("rst_mem_addr", 32'(MEM_ADDR), 32'h0);
        chk("rst_mem_d", 32'(MEM_D), 32'h0);
        mon_en = 1'b1;
        RST_N = 1'b1;
        chk("ready_before_first_edge", 32'(CMD_READY), 32'h0);
        @(posedge CLK); #1;
`ifdef RAM_INIT_CLEAR_EN
        chk("clr_busy", 32'(BUSY), 32'h1);
        rsp0 = n_rsp;
        n = 0;
        while (CMD_READY !== 1'b1 && n < 5000) begin
            @(posedge CLK); #1;
            n++;
        end
        chk("clr_ready_delay", 32'(n), 32'd4096);
        chk("clr_no_rsp", 32'(n_rsp - rsp0), 32'h0);
        do_cmd(OP_READ, 12'h000, 12'h0, 12'h0, 16'h0, r);
        chk("clr_read_000", 32'(r), 32'h0);
        do_cmd(OP_READ, 12'hFFF, 12'h0, 12'h0, 16'h0, r);
        chk("clr_read_fff", 32'(r), 32'h0);
`else
        chk("ready_after_release", 32'(CMD_READY), 32'h1);
        chk("busy_after_release", 32'(BUSY), 32'h0);
`endif

        do_cmd(OP_WRITE, 12'h000, 12'h123, 12'h0, 16'hBEEF, r);
        do_cmd(OP_READ, 12'h123, 12'h000, 12'h0, 16'h0, r);
        chk("write_then_read", 32'(r), 32'hBEEF);

        do_cmd(OP_FILL, 12'h000, 12'hFFE, 12'd3, 16'h5A5A, r);
        chk("fill_ffe", 32'(mem[12'hFFE]), 32'h5A5A);
        chk("fill_fff", 32'(mem[12'hFFF]), 32'h5A5A);
        chk("fill_wrap_000", 32'(mem[12'h000]), 32'h5A5A);
        chk("fill_wrap_001", 32'(mem[12'h001]), 32'h5A5A);
        chk("fill_untouched_002", 32'(mem[12'h002]), 32'(ref_mem[12'h002]));

        for (int i = 0; i < 4; i++) begin
            ad = 12'h010 + 12'(i);
            mem[ad] = 16'(i + 1);
            ref_mem[ad] = 16'(i + 1);
        end
        do_cmd(OP_COPY, 12'h010, 12'h200, 12'd3, 16'h0, r);
        for (int i = 0; i < 4; i++) begin
            ad = 12'h200 + 12'(i);
            chk("copy_word", 32'(mem[ad]), 32'(i + 1));
        end

        // Abort: reset sampled at the edge closing the 5th word.
        wait_ready();
        CMD_OP = OP_FILL; CMD_SRC = 12'h0; CMD_DST = 12'h300; CMD_LEN = 12'd9; CMD_DATA = 16'h1234;
        CMD_VALID = 1'b1;
        @(posedge CLK); #1;
        CMD_VALID = 1'b0;
        wr0 = n_wr; rsp0 = n_rsp;
        repeat (4) begin
            @(posedge CLK); #1;
        end
        RST_N = 1'b0;
        @(posedge CLK); #1;
        chk("abort_strobes", 32'({MEM_E, MEM_W, MEM_R}), 32'h0);
        chk("abort_busy", 32'(BUSY), 32'h0);
        chk("abort_ready", 32'(CMD_READY), 32'h0);
        @(posedge CLK); #1;
        chk("abort_words", 32'(n_wr - wr0), 32'd5);
        chk("abort_no_rsp", 32'(n_rsp - rsp0), 32'h0);
        for (int i = 0; i < 5; i++) ref_mem[12'h300 + 12'(i)] = 16'h1234;
        for (int i = 0; i < 10; i++) begin
            ad = 12'h300 + 12'(i);
            chk("abort_region", 32'(mem[ad]), 32'(ref_mem[ad]));
        end
`ifdef RAM_INIT_CLEAR_EN
        for (int i = 0; i < 4096; i++) ref_mem[i] = 16'h0;
`endif
        RST_N = 1'b1;

        for (int k = 0; k < 30; k++) begin
            do_cmd(2'($urandom), 12'($urandom), 12'($urandom), 12'($urandom_range(0, 15)),
                   16'($urandom), r);
        end

        do_cmd(OP_FILL, 12'h0, 12'($urandom), 12'd4095, 16'hC3C3, r);
        do_cmd(OP_COPY, 12'h7F0, 12'h7F2, 12'd5, 16'h0, r);
        do_cmd(OP_READ, 12'h7F7, 12'h0, 12'h0, 16'h0, r);
        do_cmd(OP_READ, 12'hFFF, 12'h0, 12'h0, 16'h0, r);

        bad = 0;
        for (int i = 0; i < 4096; i++) if (mem[i] !== ref_mem[i]) bad++;
        chk("mem_image_mismatches", 32'(bad), 32'h0);
        chk("r_and_w_same_cycle", 32'(n_both), 32'h0);
        chk("mem_e_vs_strobes", 32'(n_ebad), 32'h0);
        chk("mem_d_nonzero_idle", 32'(n_dbad), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
